// File: rtl/receiver_word_fifo_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : receiver_word_fifo_if
//  Description : Byte-in / word-out handshake bundle for receiver_word_fifo.
//  Revision    : 1.0 - initial release
// ============================================================================
interface receiver_word_fifo_if #(
    parameter int WORD_BYTES = 4,
    parameter int DEPTH      = 4
) ();
    localparam int W  = 8 * WORD_BYTES;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [7:0]    data;
    logic          valid;
    logic [W-1:0]  out_data;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] count;
    logic          overflow;
    logic          overflow_clr;
    logic          timeout_err;

    // master: byte source and word consumer side
    modport master (
        output data, valid, out_ready, overflow_clr,
        input  out_data, out_valid, count, overflow, timeout_err
    );

    // slave: the FIFO itself
    modport slave (
        input  data, valid, out_ready, overflow_clr,
        output out_data, out_valid, count, overflow, timeout_err
    );
endinterface
`default_nettype wire

// File: rtl/receiver_word_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : receiver_word_fifo
//  Description : Packs received bytes into words and queues them in a FIFO
//                with valid/ready output, overflow flag and partial timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module receiver_word_fifo #(
    parameter int WORD_BYTES = 4,
    parameter int DEPTH      = 4,
    parameter int MSB_FIRST  = 1,
    parameter int TIMEOUT    = 0
) (
    input  wire logic            clk_i,
    input  wire logic            rst_i,
    receiver_word_fifo_if.slave  rx_if
);
    localparam int W  = 8 * WORD_BYTES;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int IW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [IW-1:0] LAST_IDX  = IW'(WORD_BYTES - 1);
    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
    localparam logic [TW-1:0] IDLE_LAST = TW'(TIMEOUT - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [IW-1:0] idx_q,  idx_d;
    logic [TW-1:0] idle_q, idle_d;
    logic [W-1:0]  asm_q,  asm_d;
    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          timeout_err_q, timeout_err_d;

    logic [IW-1:0] w_slot;
    logic          w_complete;
    logic          w_full;
    logic          w_nonempty;
    logic          w_pop;
    logic          w_push;
    logic          w_drop;

    // ------------------------------------------------------------------
    // Byte assembly: the incoming byte is merged combinationally so the
    // finished word (final byte included) can be pushed on the same edge.
    // ------------------------------------------------------------------
    assign w_slot = (MSB_FIRST != 0) ? (LAST_IDX - idx_q) : idx_q;

    always_comb begin
        asm_d = asm_q;
        for (int s = 0; s < WORD_BYTES; s++) begin
            if (w_slot == IW'(s)) begin
                asm_d[s*8 +: 8] = rx_if.data;
            end
        end
    end

    always_comb begin
        idx_d         = idx_q;
        idle_d        = idle_q;
        timeout_err_d = 1'b0;
        if (rx_if.valid) begin
            idle_d = '0;
            idx_d  = (idx_q == LAST_IDX) ? '0 : idx_q + IW'(1);
        end else if ((TIMEOUT > 0) && (idx_q != '0)) begin
            // Expiry on the TIMEOUT-th idle cycle; a byte that cycle wins above.
            if (idle_q == IDLE_LAST) begin
                idx_d         = '0;
                idle_d        = '0;
                timeout_err_d = 1'b1;
            end else begin
                idle_d = idle_q + TW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // FIFO control
    // ------------------------------------------------------------------
    assign w_complete = rx_if.valid && (idx_q == LAST_IDX);
    assign w_full     = (count_q == FULL_CNT);
    assign w_nonempty = (count_q != '0);
    assign w_pop      = w_nonempty && rx_if.out_ready;
    // A full FIFO still accepts the word when the head leaves this cycle.
    assign w_push     = w_complete && (!w_full || w_pop);
    assign w_drop     = w_complete && w_full && !w_pop;

    always_comb begin
        count_d = count_q;
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    assign overflow_d = rx_if.overflow_clr ? 1'b0 : (overflow_q | w_drop);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            idx_q         <= '0;
            idle_q        <= '0;
            asm_q         <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            overflow_q    <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            idx_q         <= idx_d;
            idle_q        <= idle_d;
            count_q       <= count_d;
            overflow_q    <= overflow_d;
            timeout_err_q <= timeout_err_d;
            if (rx_if.valid) begin
                asm_q <= asm_d;
            end
            if (w_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i && w_push) begin
            mem_q[wr_ptr_q] <= asm_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign rx_if.out_valid   = w_nonempty;
    assign rx_if.out_data    = w_nonempty ? mem_q[rd_ptr_q] : '0;
    assign rx_if.count       = count_q;
    assign rx_if.overflow    = overflow_q;
    assign rx_if.timeout_err = timeout_err_q;

endmodule
`default_nettype wire

// File: tb/tb_receiver_word_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_receiver_word_fifo
//  Description : Directed bench; two DUTs (MSB-first with timeout, LSB-first
//                without) checked against a list-based model every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_receiver_word_fifo;
    localparam int WB    = 4;
    localparam int DEPTH = 4;
    localparam int W     = 8 * WB;
    localparam int NDUT  = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] s_data;
    logic       s_valid, s_ready, s_clr;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    receiver_word_fifo_if #(.WORD_BYTES(WB), .DEPTH(DEPTH)) if_a ();
    receiver_word_fifo_if #(.WORD_BYTES(WB), .DEPTH(DEPTH)) if_b ();

    assign if_a.data = s_data;  assign if_a.valid = s_valid;
    assign if_a.out_ready = s_ready;  assign if_a.overflow_clr = s_clr;
    assign if_b.data = s_data;  assign if_b.valid = s_valid;
    assign if_b.out_ready = s_ready;  assign if_b.overflow_clr = s_clr;

    receiver_word_fifo #(.WORD_BYTES(WB), .DEPTH(DEPTH), .MSB_FIRST(1), .TIMEOUT(10)) u_dut_a (
        .clk_i(clk), .rst_i(rst), .rx_if(if_a.slave));
    receiver_word_fifo #(.WORD_BYTES(WB), .DEPTH(DEPTH), .MSB_FIRST(0), .TIMEOUT(0)) u_dut_b (
        .clk_i(clk), .rst_i(rst), .rx_if(if_b.slave));

    // ------------------------------------------------------------------
    // Behavioural model: a byte list per partial word and a word list
    // per FIFO; words leave from the front of the list.
    // ------------------------------------------------------------------
    int         m_msb [NDUT] = '{1, 0};
    int         m_to  [NDUT] = '{10, 0};
    logic [7:0] m_part[NDUT][WB];
    int         m_np  [NDUT];
    logic [W-1:0] m_fifo[NDUT][DEPTH];
    int         m_n   [NDUT];
    bit         m_ovf [NDUT];
    bit         m_terr[NDUT];
    int         m_idle[NDUT];
    bit         m_live = 1'b0;

    task automatic model_step(input int d);
        logic [W-1:0] word;
        bit done, pop;
        word = '0;
        done = 1'b0;
        pop  = (m_n[d] > 0) && s_ready;
        m_terr[d] = 1'b0;
        if (s_valid) begin
            m_part[d][m_np[d]] = s_data;
            m_np[d]++;
            m_idle[d] = 0;
            if (m_np[d] == WB) begin
                for (int i = 0; i < WB; i++) begin
                    if (m_msb[d] != 0) word = (word << 8) | W'(m_part[d][i]);
                    else               word = word | (W'(m_part[d][i]) << (8 * i));
                end
                m_np[d] = 0;
                done = 1'b1;
            end
        end else if (m_to[d] > 0 && m_np[d] > 0) begin
            m_idle[d]++;
            if (m_idle[d] == m_to[d]) begin
                m_np[d] = 0;
                m_idle[d] = 0;
                m_terr[d] = 1'b1;
            end
        end
        if (pop) begin
            for (int i = 0; i < DEPTH - 1; i++) m_fifo[d][i] = m_fifo[d][i+1];
            m_n[d]--;
        end
        if (done) begin
            if (m_n[d] < DEPTH) begin
                m_fifo[d][m_n[d]] = word;
                m_n[d]++;
            end else begin
                m_ovf[d] = 1'b1;
            end
        end
        if (s_clr) m_ovf[d] = 1'b0;
    endtask

    always @(posedge clk) begin
        if (rst) begin
            for (int d = 0; d < NDUT; d++) begin
                m_np[d] = 0; m_n[d] = 0; m_ovf[d] = 1'b0;
                m_terr[d] = 1'b0; m_idle[d] = 0;
            end
            m_live = 1'b1;
        end else if (m_live) begin
            for (int d = 0; d < NDUT; d++) model_step(d);
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_dut(input int d, input logic ov, input logic [W-1:0] od,
                           input logic [2:0] cnt, input logic of, input logic te);
        logic [W-1:0] exp_head;
        exp_head = (m_n[d] > 0) ? m_fifo[d][0] : '0;
        check($sformatf("dut%0d out_valid", d), 64'(ov),  64'(m_n[d] > 0));
        check($sformatf("dut%0d out_data", d),  64'(od),  64'(exp_head));
        check($sformatf("dut%0d count", d),     64'(cnt), 64'(m_n[d]));
        check($sformatf("dut%0d overflow", d),  64'(of),  64'(m_ovf[d]));
        check($sformatf("dut%0d timeout_err", d), 64'(te), 64'(m_terr[d]));
    endtask

    always @(negedge clk) begin
        if (m_live) begin
            cmp_dut(0, if_a.out_valid, if_a.out_data, if_a.count, if_a.overflow, if_a.timeout_err);
            cmp_dut(1, if_b.out_valid, if_b.out_data, if_b.count, if_b.overflow, if_b.timeout_err);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        s_valid = 1'b1;
        s_data  = b;
        tick();
        s_valid = 1'b0;
        s_data  = 'x;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send(w[31 - 8*i -: 8]);
    endtask

    function automatic logic [31:0] swap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    task automatic check_heads(input string name, input logic [31:0] w);
        check({name, " head a"}, 64'(if_a.out_data), 64'(w));
        check({name, " head b"}, 64'(if_b.out_data), 64'(swap(w)));
    endtask

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin : stim
        int pulses, at;
        logic [31:0] exp_drain [4];
        rst = 1'b1; s_valid = 1'b0; s_data = 'x; s_ready = 1'b0; s_clr = 1'b0;
        tick(); tick();
        rst = 1'b0;
        check("reset count a", 64'(if_a.count), 64'd0);
        check("reset out_valid b", 64'(if_b.out_valid), 64'd0);
        check("reset out_data a", 64'(if_a.out_data), 64'd0);

        // Single word, one cycle latency
        send_word(32'h12345678);
        check("t1 out_valid a", 64'(if_a.out_valid), 64'd1);
        check("t1 data a", 64'(if_a.out_data), 64'h12345678);
        check("t1 data b", 64'(if_b.out_data), 64'h78563412);
        check("t1 count a", 64'(if_a.count), 64'd1);
        s_ready = 1'b1; tick(); s_ready = 1'b0;
        check("t1 drained", 64'(if_a.count), 64'd0);

        // Back-to-back words
        send_word(32'hA1A2A3A4);
        send_word(32'hB1B2B3B4);
        check("t2 count a", 64'(if_a.count), 64'd2);
        check_heads("t2", 32'hA1A2A3A4);
        s_ready = 1'b1; tick(); check_heads("t2 second", 32'hB1B2B3B4);
        tick(); s_ready = 1'b0;

        // Overflow with DEPTH+1 words
        for (int k = 0; k < 5; k++) send_word({4'(k), 4'h0, 4'(k), 4'h1, 4'(k), 4'h2, 4'(k), 4'h3});
        check("t3 count", 64'(if_a.count), 64'd4);
        check("t3 overflow", 64'(if_a.overflow), 64'd1);
        check_heads("t3", 32'h00010203);
        s_clr = 1'b1; tick(); s_clr = 1'b0;
        check("t3 overflow cleared", 64'(if_a.overflow), 64'd0);
        s_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check_heads("t3 drain", {4'(k), 4'h0, 4'(k), 4'h1, 4'(k), 4'h2, 4'(k), 4'h3});
            tick();
        end
        s_ready = 1'b0;
        check("t3 empty", 64'(if_b.count), 64'd0);

        // Full: clear beats set, then push concurrent with pop
        for (int k = 0; k < 4; k++) send_word({4'(k), 4'h0, 4'(k), 4'h1, 4'(k), 4'h2, 4'(k), 4'h3});
        send(8'h60); send(8'h61); send(8'h62);
        s_clr = 1'b1; send(8'h63); s_clr = 1'b0;
        check("t4 clr priority", 64'(if_a.overflow), 64'd0);
        send(8'h50); send(8'h51); send(8'h52);
        s_ready = 1'b1; send(8'h53); s_ready = 1'b0;
        check("t4 count", 64'(if_a.count), 64'd4);
        check("t4 overflow", 64'(if_b.overflow), 64'd0);
        exp_drain = '{32'h10111213, 32'h20212223, 32'h30313233, 32'h50515253};
        s_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check_heads("t4 drain", exp_drain[k]);
            tick();
        end
        tick();
        s_ready = 1'b0;
        check("t4 empty pop", 64'(if_a.count), 64'd0);

        // Timeout on dut a; dut b keeps its partial word
        send(8'hAA); send(8'hBB);
        pulses = 0; at = 0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (if_a.timeout_err === 1'b1) begin pulses++; at = i; end
        end
        check("t5 pulse count", 64'(pulses), 64'd1);
        check("t5 pulse cycle", 64'(at), 64'd10);
        check("t5 no word", 64'(if_a.count), 64'd0);
        send_word(32'h11223344);
        check("t5 word a", 64'(if_a.out_data), 64'h11223344);
        check("t5 word b", 64'(if_b.out_data), 64'h2211BBAA);
        // Byte arriving on the would-be expiry cycle keeps the word alive
        send(8'hC1);
        pulses = 0;
        for (int i = 0; i < 9; i++) begin
            tick();
            if (if_a.timeout_err === 1'b1) pulses++;
        end
        send(8'hC2); send(8'hC3); send(8'hC4);
        if (if_a.timeout_err === 1'b1) pulses++;
        check("t5 valid wins", 64'(pulses), 64'd0);
        check("t5 word count a", 64'(if_a.count), 64'd2);

        // Reset with queued words and a partial word
        send(8'hE1); send(8'hE2);
        rst = 1'b1; tick(); rst = 1'b0;
        check("t6 count", 64'(if_a.count), 64'd0);
        check("t6 out_valid", 64'(if_b.out_valid), 64'd0);
        send_word(32'hD1D2D3D4);
        check_heads("t6 clean", 32'hD1D2D3D4);
        check("t6 count after", 64'(if_a.count), 64'd1);

        tick(); tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
